mmio_bank: RTL and testbench

Parametrised memory-mapped I/O bank on the CPU data path, successor to the single-register MMIO decoder. It decodes the MMIO window, drives `NUM_SEG` active-low seven-segment channels, and replaces the single toggle-handshake UART register with a `UART_FIFO_DEPTH`-entry transmit FIFO. The FIFO has a ready/valid drain port and a readable status/overflow register. Writes and reads come from pipeline stage 2, gated by `clk_enable`; the FIFO drain side runs every `clk` cycle.

---
 rtl/mmio_bank.sv | 89 ++++++++
 tb/tb_mmio_bank.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/mmio_bank.sv
// mmio_bank: MMIO window decoder with seven-segment channels and a UART transmit FIFO
package microcode;
  localparam int WIDTH = 8;
  function automatic logic mcs2_mem_we(input logic [WIDTH-1:0] mc);
    return mc[0];
  endfunction
endpackage

module mmio_bank #(
  parameter int MMIO_ADDR_START_BIT = 16,
  parameter int NUM_SEG = 2,
  parameter int UART_FIFO_DEPTH = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clk_enable,
  input  logic [microcode::WIDTH-1:0] microcode_s2,
  input  logic [31:0]                 addr,
  input  logic [31:0]                 data_in,
  output logic [31:0]                 data_out,
  output logic                        is_mmio,
  output logic [16*NUM_SEG-1:0]       seven_segment_out,
  output logic [7:0]                  uart_tx_data,
  output logic                        uart_tx_valid,
  input  logic                        uart_tx_ready
);
  localparam int AW = $clog2(UART_FIFO_DEPTH);
  localparam int OW = MMIO_ADDR_START_BIT;
  logic [OW-1:0] off;
  logic [5:0] seg_idx;
  logic acc, we, seg_hit, tx_hit, st_hit, full, empty, pop, push_req, push, ovf;
  logic [15:0] seg [NUM_SEG];
  logic [15:0] seg_rd;
  logic [7:0] mem [UART_FIFO_DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW:0] count;
  logic [31:0] rdata;
  logic unused;
  assign unused = ^{addr[31:OW], data_in[30:16], microcode_s2};
  assign off = addr[OW-1:0];
  assign is_mmio = addr[OW];
  assign acc = clk_enable & is_mmio;
  assign we = microcode::mcs2_mem_we(microcode_s2);
  assign seg_idx = off[7:2];
  assign seg_hit = (off[OW-1:8] == '0) && (off[1:0] == 2'b00) && (int'(seg_idx) < NUM_SEG);
  assign tx_hit = off == OW'('h100);
  assign st_hit = off == OW'('h104);
  for (genvar i = 0; i < NUM_SEG; i++) begin : g_seg
    assign seven_segment_out[16*i +: 16] = seg[i];
  end
  always_comb begin
    seg_rd = '0;
    for (int i = 0; i < NUM_SEG; i++) if (seg_idx == 6'(i)) seg_rd = ~seg[i];
  end
  assign empty = count == '0;
  assign full = count == (AW+1)'(UART_FIFO_DEPTH);
  assign uart_tx_valid = !empty;
  // The array is never reset, so the head is masked while nothing is queued.
  assign uart_tx_data = empty ? 8'h00 : mem[rd_ptr];
  assign pop = uart_tx_valid & uart_tx_ready;
  assign push_req = acc & we & tx_hit;
  assign push = push_req & (!full | pop);
  assign rdata = seg_hit ? {16'b0, seg_rd} :
                 tx_hit  ? {24'b0, uart_tx_data} :
                 st_hit  ? {ovf, 14'b0, full, empty, 6'b0, 9'(count)} : 32'h0;
  always_ff @(posedge clk) if (push) mem[wr_ptr] <= data_in[7:0];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      for (int i = 0; i < NUM_SEG; i++) seg[i] <= '1;
    end else begin
      for (int i = 0; i < NUM_SEG; i++)
        if (acc && we && seg_hit && seg_idx == 6'(i)) seg[i] <= ~data_in[15:0];
    end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
      ovf <= 1'b0;
      data_out <= '0;
    end else begin
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      if (push) wr_ptr <= wr_ptr + AW'(1);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
      if (push_req && full && !pop) ovf <= 1'b1;
      else if (acc && we && st_hit && data_in[31]) ovf <= 1'b0;
      if (acc) data_out <= rdata;
    end
endmodule

// File: tb/tb_mmio_bank.sv
// tb_mmio_bank: randomized self-checking bench against a queue-based reference model
module tb_mmio_bank;
  localparam int NSEG = 2;
  localparam int DEPTH = 8;
  localparam logic [31:0] MM = 32'h0001_0000;
  logic clk = 1'b0, rst = 1'b1, clk_enable = 1'b0, uart_tx_ready = 1'b0;
  logic [microcode::WIDTH-1:0] microcode_s2 = '0;
  logic [31:0] addr = '0, data_in = '0;
  logic [31:0] data_out;
  logic is_mmio, uart_tx_valid;
  logic [16*NSEG-1:0] seven_segment_out;
  logic [7:0] uart_tx_data;
  int checks = 0, errors = 0;
  logic [15:0] m_seg [NSEG];
  logic [7:0] q[$];
  logic m_ovf = 1'b0;
  logic [31:0] m_dout = '0;

  mmio_bank #(.MMIO_ADDR_START_BIT(16), .NUM_SEG(NSEG), .UART_FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .clk_enable(clk_enable), .microcode_s2(microcode_s2),
    .addr(addr), .data_in(data_in), .data_out(data_out), .is_mmio(is_mmio),
    .seven_segment_out(seven_segment_out), .uart_tx_data(uart_tx_data),
    .uart_tx_valid(uart_tx_valid), .uart_tx_ready(uart_tx_ready));

  always #5 clk = ~clk;

  function automatic logic [31:0] m_segs();
    return {~m_seg[1], ~m_seg[0]};
  endfunction

  function automatic logic [7:0] m_head();
    return q.size() != 0 ? q[0] : 8'h00;
  endfunction

  function automatic logic [31:0] m_read(input logic [15:0] off);
    if (off < 16'(4*NSEG) && off[1:0] == 2'b00) return {16'b0, m_seg[int'(off[15:2])]};
    if (off == 16'h100) return {24'b0, m_head()};
    if (off == 16'h104)
      return {m_ovf, 14'b0, q.size() == DEPTH, q.size() == 0, 6'b0, 9'(q.size())};
    return 32'h0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NSEG; i++) m_seg[i] = 16'h0000;
    q.delete();
    m_ovf = 1'b0;
    m_dout = '0;
  endtask

  // Drives one cycle of stimulus and advances the model using pre-edge state.
  task automatic step(input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic rdy, input logic en);
    logic [15:0] off;
    logic acc, full, pop, preq;
    microcode_s2 = '0;
    microcode_s2[0] = w;
    addr = a;
    data_in = d;
    uart_tx_ready = rdy;
    clk_enable = en;
    off = a[15:0];
    acc = en && a[16];
    full = q.size() == DEPTH;
    pop = rdy && q.size() != 0;
    preq = acc && w && off == 16'h100;
    if (acc) m_dout = m_read(off);
    if (acc && w && off < 16'(4*NSEG) && off[1:0] == 2'b00) m_seg[int'(off[15:2])] = d[15:0];
    if (pop) void'(q.pop_front());
    if (preq && (!full || pop)) q.push_back(d[7:0]);
    if (preq && full && !pop) m_ovf = 1'b1;
    else if (acc && w && off == 16'h104 && d[31]) m_ovf = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) step(1, MM | 32'h100, $urandom, 0, 1);
    step(1, MM, 32'h0000_00FF, 0, 1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    model_reset();
    checks++; if (seven_segment_out !== 32'hFFFF_FFFF) begin errors++; $display("FAIL reset_seg: got %h exp %h", seven_segment_out, 32'hFFFF_FFFF); end
    checks++; if (uart_tx_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b exp 0", uart_tx_valid); end
    checks++; if (uart_tx_data !== 8'h00) begin errors++; $display("FAIL reset_txdata: got %h exp 00", uart_tx_data); end
    checks++; if (data_out !== 32'h0) begin errors++; $display("FAIL reset_dout: got %h exp 0", data_out); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(0, MM | 32'h104, 0, 0, 1);
    checks++; if (data_out !== 32'h0000_8000) begin errors++; $display("FAIL reset_status: got %h exp %h", data_out, 32'h0000_8000); end
  endtask

  task automatic test_seg();
    logic [15:0] offs [6] = '{16'h000, 16'h004, 16'h008, 16'h002, 16'h080, 16'h00C};
    step(1, MM, 32'h1234, 0, 1);
    step(1, MM | 32'h4, 32'hBEEF, 0, 1);
    checks++; if (seven_segment_out !== 32'h4110_EDCB) begin errors++; $display("FAIL seg_write: got %h exp %h", seven_segment_out, 32'h4110_EDCB); end
    step(0, MM | 32'h4, 0, 0, 1);
    checks++; if (data_out !== 32'h0000_BEEF) begin errors++; $display("FAIL seg_read: got %h exp %h", data_out, 32'h0000_BEEF); end
    step(1, MM | 32'h8, 32'hFFFF, 0, 1);
    checks++; if (seven_segment_out !== 32'h4110_EDCB) begin errors++; $display("FAIL seg_bad_off: got %h exp %h", seven_segment_out, 32'h4110_EDCB); end
    for (int i = 0; i < 20; i++) begin
      step(1'($urandom), MM | 32'(offs[$urandom_range(0, 5)]), $urandom, 0, 1);
      checks++; if (seven_segment_out !== m_segs()) begin errors++; $display("FAIL seg_rand: got %h exp %h", seven_segment_out, m_segs()); end
      checks++; if (data_out !== m_dout) begin errors++; $display("FAIL seg_rand_dout: got %h exp %h", data_out, m_dout); end
    end
  endtask

  task automatic test_fifo_order();
    logic [7:0] exp [3] = '{8'h41, 8'h42, 8'h43};
    for (int i = 0; i < 3; i++) step(1, MM | 32'h100, {24'hABCDEF, exp[i]}, 0, 1);
    checks++; if (uart_tx_valid !== 1'b1 || uart_tx_data !== 8'h41) begin errors++; $display("FAIL fifo_head: got %b/%h exp 1/41", uart_tx_valid, uart_tx_data); end
    step(0, MM | 32'h104, 0, 0, 1);
    checks++; if (data_out !== 32'h0000_0003) begin errors++; $display("FAIL fifo_count3: got %h exp 3", data_out); end
    step(0, MM | 32'h100, 0, 0, 1);
    checks++; if (data_out !== 32'h0000_0041) begin errors++; $display("FAIL fifo_txread: got %h exp 41", data_out); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (uart_tx_data !== exp[i]) begin errors++; $display("FAIL fifo_drain%0d: got %h exp %h", i, uart_tx_data, exp[i]); end
      step(0, 32'h0, 0, 1, 1);
    end
    checks++; if (uart_tx_valid !== 1'b0 || uart_tx_data !== 8'h00) begin errors++; $display("FAIL fifo_empty: got %b/%h exp 0/00", uart_tx_valid, uart_tx_data); end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 8; i++) step(1, MM | 32'h100, $urandom, 0, 1);
    step(0, MM | 32'h104, 0, 0, 1);
    checks++; if (data_out !== 32'h0001_0008) begin errors++; $display("FAIL ovf_full: got %h exp %h", data_out, 32'h0001_0008); end
    step(1, MM | 32'h100, $urandom, 0, 1);
    step(0, MM | 32'h104, 0, 0, 1);
    checks++; if (data_out !== 32'h8001_0008) begin errors++; $display("FAIL ovf_set: got %h exp %h", data_out, 32'h8001_0008); end
    checks++; if (uart_tx_data !== m_head()) begin errors++; $display("FAIL ovf_head: got %h exp %h", uart_tx_data, m_head()); end
    step(1, MM | 32'h104, 32'h8000_0000, 0, 1);
    step(0, MM | 32'h104, 0, 0, 1);
    checks++; if (data_out !== 32'h0001_0008) begin errors++; $display("FAIL ovf_clear: got %h exp %h", data_out, 32'h0001_0008); end
  endtask

  task automatic test_back_to_back();
    step(1, MM | 32'h100, 32'h55, 1, 1);
    step(0, MM | 32'h104, 0, 0, 1);
    checks++; if (data_out !== 32'h0001_0008) begin errors++; $display("FAIL b2b_full_push: got %h exp %h", data_out, 32'h0001_0008); end
    for (int i = 0; i < 8; i++) begin
      checks++; if (uart_tx_data !== m_head()) begin errors++; $display("FAIL b2b_swap%0d: got %h exp %h", i, uart_tx_data, m_head()); end
      step(1, MM | 32'h100, $urandom, 1, 1);
    end
    step(0, MM | 32'h104, 0, 0, 1);
    checks++; if (data_out !== 32'h0001_0008) begin errors++; $display("FAIL b2b_count: got %h exp %h", data_out, 32'h0001_0008); end
    for (int i = 0; i < 8; i++) begin
      checks++; if (uart_tx_data !== m_head()) begin errors++; $display("FAIL b2b_drain%0d: got %h exp %h", i, uart_tx_data, m_head()); end
      step(0, 32'h0, 0, 1, 1);
    end
    checks++; if (uart_tx_valid !== 1'b0) begin errors++; $display("FAIL b2b_empty: got %b exp 0", uart_tx_valid); end
  endtask

  task automatic test_gating();
    logic [31:0] seg0, dout0;
    for (int i = 0; i < 3; i++) step(1, MM | 32'h100, $urandom, 0, 1);
    step(0, MM | 32'h4, 0, 0, 1);
    seg0 = m_segs();
    dout0 = m_dout;
    for (int i = 0; i < 4; i++) begin
      checks++; if (uart_tx_data !== m_head()) begin errors++; $display("FAIL gate_head%0d: got %h exp %h", i, uart_tx_data, m_head()); end
      step(1, MM | ((i % 2) ? 32'h100 : 32'h0), $urandom, 1, 0);
      checks++; if (seven_segment_out !== seg0 || data_out !== dout0) begin errors++; $display("FAIL gate_hold%0d: got %h/%h exp %h/%h", i, seven_segment_out, data_out, seg0, dout0); end
    end
    checks++; if (uart_tx_valid !== 1'b0) begin errors++; $display("FAIL gate_no_push: got %b exp 0", uart_tx_valid); end
  endtask

  task automatic test_random();
    logic [15:0] offs [7] = '{16'h000, 16'h004, 16'h008, 16'h100, 16'h104, 16'h108, 16'h0FC};
    logic [31:0] a;
    for (int i = 0; i < 300; i++) begin
      a = {15'($urandom), ($urandom_range(0, 7) != 0), offs[$urandom_range(0, 6)]};
      step(($urandom_range(0, 2) != 0), a, $urandom, 1'($urandom), ($urandom_range(0, 4) != 0));
      checks++; if (is_mmio !== a[16]) begin errors++; $display("FAIL rand_is_mmio: got %b exp %b", is_mmio, a[16]); end
      checks++; if (seven_segment_out !== m_segs()) begin errors++; $display("FAIL rand_seg: got %h exp %h", seven_segment_out, m_segs()); end
      checks++; if (uart_tx_valid !== (q.size() != 0) || uart_tx_data !== m_head()) begin errors++; $display("FAIL rand_tx: got %b/%h exp %b/%h", uart_tx_valid, uart_tx_data, q.size() != 0, m_head()); end
      checks++; if (data_out !== m_dout) begin errors++; $display("FAIL rand_dout: got %h exp %h", data_out, m_dout); end
    end
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    test_reset();
    test_seg();
    test_fifo_order();
    test_overflow();
    test_back_to_back();
    test_gating();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
